// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : parametrised multi-cycle integer ALU
//
// Sits between decode and writeback. An operation is sampled when
// in_valid && in_ready. Single-cycle ops present a registered result on
// rd_data one cycle after accept; signed div/rem run on an iterative
// restoring divider and present their result XLEN+1 cycles after accept.
// The result is held with out_valid high until out_ready is seen.
//
// Optional feature macro: ALU_DIV_EN
//   defined   : divider and DIV state built; opcodes 1101/1110 give signed
//               quotient / remainder.
//   undefined : no divider; 1101/1110 complete in one cycle with result 0,
//               busy is tied low.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   operation request valid
//   in_ready   out  an operation can be accepted this cycle
//   is_lui     in   result = imm << 12 (highest priority)
//   is_i_type  in   result = rs1 + imm
//   alu_ops    in   opcode when neither is_lui nor is_i_type
//   rs1_data   in   operand 1
//   rs2_data   in   operand 2 (shift amount uses the low SHW bits)
//   imm        in   immediate
//   out_valid  out  rd_data valid
//   out_ready  in   consumer accepts rd_data
//   rd_data    out  result
//   busy       out  divider iterating
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_lui,
   input  logic            is_i_type,
   input  logic [3:0]      alu_ops,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd_data,
   output logic            busy
);

`ifdef ALU_DIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_DIV = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

   state_t            state_q, state_d;
   logic [XLEN-1:0]   rd_q, rd_d;
   logic              accept;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   alu_res;

   assign shamt     = rs2_data[SHW-1:0];
   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign rd_data   = rd_q;

   // Single-cycle result; div/rem opcodes fall to the default 0 here and are
   // diverted to the divider below when it is built.
   always_comb begin
      alu_res = '0;
      if (is_lui) begin
         alu_res = imm << 12;
      end else if (is_i_type) begin
         alu_res = rs1_data + imm;
      end else begin
         case (alu_ops)
            4'b0000: alu_res = rs1_data + rs2_data;
            4'b0001: alu_res = rs1_data - rs2_data;
            4'b0010: alu_res = rs1_data ^ rs2_data;
            4'b0011: alu_res = rs1_data | rs2_data;
            4'b0100: alu_res = rs1_data & rs2_data;
            4'b0101: alu_res = rs1_data << shamt;
            4'b0110: alu_res = rs1_data >> shamt;
            4'b0111: alu_res = $signed(rs1_data) >>> shamt;
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, (rs1_data < rs2_data)};
            4'b1100: alu_res = rs1_data * rs2_data;
            default: alu_res = '0;
         endcase
      end
   end

`ifdef ALU_DIV_EN
   localparam int CW = SHW + 1;

   logic              is_div_op;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;      // partial remainder
   logic [XLEN-1:0]   quo_q, quo_d;      // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   dvs_q, dvs_d;      // |divisor|
   logic              neg_q_q, neg_q_d;  // negate quotient at the end
   logic              neg_r_q, neg_r_d;  // negate remainder at the end
   logic              dz_q, dz_d;        // divide by zero
   logic              op_rem_q, op_rem_d;
   logic [XLEN:0]     trial;
   logic              ge;
   logic [XLEN-1:0]   rem_step, quo_step;

   assign is_div_op = !is_lui && !is_i_type && ((alu_ops == 4'b1101) || (alu_ops == 4'b1110));

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. The remainder stays below the divisor,
   // so it always fits back into XLEN bits.
   always_comb begin
      trial    = {rem_q, quo_q[XLEN-1]};
      ge       = (trial >= {1'b0, dvs_q});
      rem_step = ge ? XLEN'(trial - {1'b0, dvs_q}) : trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], ge};
   end
`endif

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
`ifdef ALU_DIV_EN
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
      op_rem_d = op_rem_q;
`endif
      case (state_q)
         S_DONE: if (out_ready) state_d = S_IDLE;
`ifdef ALU_DIV_EN
         S_DIV: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
            // Last quotient bit: apply sign correction in the same cycle.
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               if (op_rem_q)
                  rd_d = neg_r_q ? -rem_step : rem_step;
               else if (dz_q)
                  rd_d = '1;
               else
                  rd_d = neg_q_q ? -quo_step : quo_step;
            end
         end
`endif
         default: ;
      endcase

      // Accept is only possible from IDLE or a DONE being drained, so it
      // overrides the DONE->IDLE transition above.
      if (accept) begin
`ifdef ALU_DIV_EN
         if (is_div_op) begin
            state_d  = S_DIV;
            cnt_d    = CW'(XLEN);
            rem_d    = '0;
            quo_d    = rs1_data[XLEN-1] ? -rs1_data : rs1_data;
            dvs_d    = rs2_data[XLEN-1] ? -rs2_data : rs2_data;
            dz_d     = (rs2_data == '0);
            neg_q_d  = rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
            neg_r_d  = rs1_data[XLEN-1];
            op_rem_d = alu_ops[1];
         end else begin
            state_d = S_DONE;
            rd_d    = alu_res;
         end
`else
         state_d = S_DONE;
         rd_d    = alu_res;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rd_q    <= '0;
`ifdef ALU_DIV_EN
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         op_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
`ifdef ALU_DIV_EN
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
         op_rem_q <= op_rem_d;
`endif
      end
   end

`ifdef ALU_DIV_EN
   assign busy = (state_q == S_DIV);
`else
   assign busy = 1'b0;
`endif

endmodule
